// File: rtl/aes_dec_pkg.sv
// aes_dec_pkg: shared types, round constants and GF(2^8) helpers for the AES-128 inverse cipher
package aes_dec_pkg;
  typedef enum logic [1:0] {IDLE, KEYEXP, ROUND, DONE} state_t;
  localparam logic [3:0] LAST_KEY_STEP = 4'd9;
  localparam logic [3:0] FIRST_ROUND = 4'd9;
  localparam logic [79:0] RCON = 80'h01020408102040801b36;
  function automatic logic [7:0] rcon(input logic [3:0] i);
    return (i < 4'd10) ? RCON[79 - 8*int'(i) -: 8] : 8'h00;
  endfunction
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction
  // x^254 is the multiplicative inverse in GF(2^8), and maps 0 to 0
  function automatic logic [7:0] gf_inv(input logic [7:0] a);
    logic [7:0] p, r;
    p = a;
    r = 8'h01;
    for (int i = 0; i < 7; i++) begin
      p = gmul(p, p);
      r = gmul(r, p);
    end
    return r;
  endfunction
  function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
    return (b << n) | (b >> (8 - n));
  endfunction
  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] b;
    b = gf_inv(a);
    return b ^ rotl8(b, 1) ^ rotl8(b, 2) ^ rotl8(b, 3) ^ rotl8(b, 4) ^ 8'h63;
  endfunction
  function automatic logic [7:0] inv_sbox(input logic [7:0] a);
    return gf_inv(rotl8(a, 1) ^ rotl8(a, 3) ^ rotl8(a, 6) ^ 8'h05);
  endfunction
  function automatic logic [31:0] inv_mix_col(input logic [31:0] c);
    logic [7:0] a0, a1, a2, a3;
    {a0, a1, a2, a3} = c;
    return {gmul(a0, 8'h0e) ^ gmul(a1, 8'h0b) ^ gmul(a2, 8'h0d) ^ gmul(a3, 8'h09),
            gmul(a0, 8'h09) ^ gmul(a1, 8'h0e) ^ gmul(a2, 8'h0b) ^ gmul(a3, 8'h0d),
            gmul(a0, 8'h0d) ^ gmul(a1, 8'h09) ^ gmul(a2, 8'h0e) ^ gmul(a3, 8'h0b),
            gmul(a0, 8'h0b) ^ gmul(a1, 8'h0d) ^ gmul(a2, 8'h09) ^ gmul(a3, 8'h0e)};
  endfunction
  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction
  function automatic logic [127:0] key_fwd(input logic [127:0] k, input logic [7:0] rc);
    logic [31:0] n0, n1, n2, n3;
    n0 = k[127:96] ^ sub_word({k[23:0], k[31:24]}) ^ {rc, 24'h0};
    n1 = k[95:64] ^ n0;
    n2 = k[63:32] ^ n1;
    n3 = k[31:0] ^ n2;
    return {n0, n1, n2, n3};
  endfunction
  function automatic logic [127:0] key_inv(input logic [127:0] k, input logic [7:0] rc);
    logic [31:0] w0, w1, w2, w3;
    w3 = k[31:0] ^ k[63:32];
    w2 = k[63:32] ^ k[95:64];
    w1 = k[95:64] ^ k[127:96];
    w0 = k[127:96] ^ sub_word({w3[23:0], w3[31:24]}) ^ {rc, 24'h0};
    return {w0, w1, w2, w3};
  endfunction
endpackage

// File: rtl/aes_inv_round.sv
// aes_inv_round: one combinational AES inverse round (InvShiftRows, InvSubBytes, AddRoundKey, InvMixColumns)
module aes_inv_round
  import aes_dec_pkg::*;
(
  input  logic [127:0] st_i,
  input  logic [127:0] rk_i,
  input  logic         last_i,
  output logic [127:0] st_o
);
  logic [127:0] sb, ak, mc;
  always_comb begin
    sb = '0;
    mc = '0;
    for (int i = 0; i < 16; i++)
      sb[127-8*i -: 8] = inv_sbox(st_i[127-8*(4*(((i/4)-(i%4)+4)%4)+(i%4)) -: 8]);
    ak = sb ^ rk_i;
    for (int c = 0; c < 4; c++)
      mc[127-32*c -: 32] = inv_mix_col(ak[127-32*c -: 32]);
    st_o = last_i ? ak : mc;
  end
endmodule

// File: rtl/aes_decrypt_top.sv
// aes_decrypt_top: iterative AES-128 decryptor, one round per clock.
// Optional rk10 key cache enabled by defining AES_DEC_KEY_CACHE_EN.
module aes_decrypt_top
  import aes_dec_pkg::*;
(
  input  logic         AES_clk,
  input  logic         AES_rst_n,
  input  logic         AES_en,
  input  logic [127:0] AES_data_in,
  input  logic [127:0] AES_key_in,
  output logic [127:0] AES_data_out,
  output logic         AES_data_out_valid
);
  state_t state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic [127:0] st_q, st_d, key_q, key_d, out_q, out_d, rk_fwd, rk_inv, rnd_out;
  logic vld_q, vld_d, en_q, en_d, start;
`ifdef AES_DEC_KEY_CACHE_EN
  logic [127:0] orig_q, orig_d, ck_key_q, ck_key_d, ck_rk_q, ck_rk_d;
  logic ck_vld_q, ck_vld_d;
`endif
  assign rk_fwd = key_fwd(key_q, rcon(cnt_q));
  // key_q holds rk(r+1) while in ROUND r, so the inverse step yields this round's key
  assign rk_inv = key_inv(key_q, rcon(cnt_q));
  assign start = (state_q == IDLE) && AES_en && !en_q;
  aes_inv_round u_round (.st_i(st_q), .rk_i(rk_inv), .last_i(cnt_q == 4'd0), .st_o(rnd_out));
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    st_d = st_q;
    key_d = key_q;
    out_d = out_q;
    vld_d = 1'b0;
    en_d = AES_en;
`ifdef AES_DEC_KEY_CACHE_EN
    orig_d = orig_q;
    ck_key_d = ck_key_q;
    ck_rk_d = ck_rk_q;
    ck_vld_d = ck_vld_q;
`endif
    case (state_q)
      IDLE: if (start) begin
        st_d = AES_data_in;
        key_d = AES_key_in;
        cnt_d = 4'd0;
        state_d = KEYEXP;
`ifdef AES_DEC_KEY_CACHE_EN
        orig_d = AES_key_in;
        if (ck_vld_q && AES_key_in == ck_key_q) begin
          st_d = AES_data_in ^ ck_rk_q;
          key_d = ck_rk_q;
          cnt_d = FIRST_ROUND;
          state_d = ROUND;
        end
`endif
      end
      KEYEXP: begin
        key_d = rk_fwd;
        cnt_d = cnt_q + 4'd1;
        if (cnt_q == LAST_KEY_STEP) begin
          st_d = st_q ^ rk_fwd;
          cnt_d = FIRST_ROUND;
          state_d = ROUND;
`ifdef AES_DEC_KEY_CACHE_EN
          ck_key_d = orig_q;
          ck_rk_d = rk_fwd;
          ck_vld_d = 1'b1;
`endif
        end
      end
      ROUND: begin
        st_d = rnd_out;
        key_d = rk_inv;
        cnt_d = (cnt_q == 4'd0) ? 4'd0 : cnt_q - 4'd1;
        state_d = (cnt_q == 4'd0) ? DONE : ROUND;
      end
      DONE: begin
        out_d = st_q;
        vld_d = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge AES_clk or negedge AES_rst_n)
    if (!AES_rst_n) begin
      state_q <= IDLE;
      cnt_q <= 4'd0;
      st_q <= '0;
      key_q <= '0;
      out_q <= '0;
      vld_q <= 1'b0;
      en_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      st_q <= st_d;
      key_q <= key_d;
      out_q <= out_d;
      vld_q <= vld_d;
      en_q <= en_d;
    end
`ifdef AES_DEC_KEY_CACHE_EN
  always_ff @(posedge AES_clk or negedge AES_rst_n)
    if (!AES_rst_n) begin
      orig_q <= '0;
      ck_key_q <= '0;
      ck_rk_q <= '0;
      ck_vld_q <= 1'b0;
    end else begin
      orig_q <= orig_d;
      ck_key_q <= ck_key_d;
      ck_rk_q <= ck_rk_d;
      ck_vld_q <= ck_vld_d;
    end
`endif
  assign AES_data_out = out_q;
  assign AES_data_out_valid = vld_q;
endmodule

// File: tb/tb_aes_decrypt_top.sv
// tb_aes_decrypt_top: directed FIPS-197 vectors, latency, retrigger, input-change and reset-abort checks
module tb_aes_decrypt_top;
  logic clk = 1'b0, rst_n = 1'b0, en = 1'b0;
  logic [127:0] din = '0, kin = '0, dout;
  logic vld;
  int checks = 0, errors = 0, pulses = 0, p0;
  localparam logic [127:0] K1 = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] C1 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] P1 = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] K2 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] C2 = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] P2 = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] C3 = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;
  aes_decrypt_top dut (
    .AES_clk(clk), .AES_rst_n(rst_n), .AES_en(en), .AES_data_in(din),
    .AES_key_in(kin), .AES_data_out(dout), .AES_data_out_valid(vld)
  );
  always #5 clk = ~clk;
  always @(negedge clk) if (vld) pulses++;
  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", tag, got, exp);
    end
  endtask
  task automatic scramble();
    din = {$urandom(), $urandom(), $urandom(), $urandom()};
    kin = {$urandom(), $urandom(), $urandom(), $urandom()};
  endtask
  task automatic run(input string tag, input logic [127:0] d, input logic [127:0] k,
                     input logic [127:0] exp, input int lat, input bit hold, input bit scr);
    int n = 0;
    int q0;
    @(negedge clk);
    din = d;
    kin = k;
    en = 1'b1;
    @(posedge clk);
    q0 = pulses;
    #1;
    if (!hold) en = 1'b0;
    if (scr) scramble();
    do begin
      @(posedge clk);
      n++;
      #1;
      if (scr) scramble();
    end while (!vld && n < 60);
    check({tag, " latency"}, 128'(n), 128'(lat));
    check({tag, " data"}, dout, exp);
    if (hold) repeat (50 - n) @(posedge clk);
    #1 en = 1'b0;
    repeat (3) @(posedge clk);
    check({tag, " pulses"}, 128'(pulses - q0), 128'd1);
  endtask
  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask
  initial begin
    #1;
    check("reset data_out", dout, '0);
    check("reset valid", 128'(vld), '0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    run("fips_c1", C1, K1, P1, 21, 1'b0, 1'b0);
    run("fips_b_hold", C2, K2, P2, 21, 1'b1, 1'b0);
    @(negedge clk);
    din = C1;
    kin = K1;
    en = 1'b1;
    @(posedge clk);
    p0 = pulses;
    #1 en = 1'b0;
    repeat (12) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("abort data_out", dout, '0);
    check("abort valid", 128'(vld), '0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (30) @(posedge clk);
    #1 check("abort pulses", 128'(pulses - p0), '0);
    run("restart_c1", C1, K1, P1, 21, 1'b0, 1'b0);
    run("zero_scramble", C3, '0, '0, 21, 1'b0, 1'b1);
`ifdef AES_DEC_KEY_CACHE_EN
    do_reset();
    run("cache_cold", C1, K1, P1, 21, 1'b0, 1'b0);
    run("cache_hit", C1, K1, P1, 11, 1'b0, 1'b0);
    run("cache_miss", C2, K2, P2, 21, 1'b0, 1'b0);
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
  initial begin
    #1000000;
    $display("FAIL timeout reached");
    $fatal(1, "timeout");
  end
endmodule
